// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: command-driven controller for an external 4-bit
// universal shift register (USR). It takes one command at a time over
// valid/ready and drives the USR MODE/din for N cycles. Rotations feed
// usr_dout back to usr_din. When the command finishes, it captures the
// register value and pulses done.
// Optional build macro: USR_SEQ_MOD_EN. When it is defined, the rotate count
// is reduced modulo WIDTH at accept time.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_din,
  input  logic [WIDTH-1:0] usr_dout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] cnt_eff;
  logic             accept;
  logic             is_rot;

  // Effective rotate count. A full turn of WIDTH steps is the identity, so the
  // reduced count gives the same final value in fewer EXEC cycles.
`ifdef USR_SEQ_MOD_EN
  assign cnt_eff = cmd_count & CNT_W'(WIDTH - 1);
`else
  assign cnt_eff = cmd_count;
`endif

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign is_rot    = (cmd_op != OP_NOP) && (cmd_op != OP_LOAD);
  assign busy      = (state == S_EXEC) || (state == S_CAPT);

  // USR drive. The USR only moves in EXEC. A rotate feeds its own contents
  // back so that it steps once per cycle.
  always_comb begin
    usr_mode = 2'b00;
    usr_din  = '0;
    if (!rst && state == S_EXEC) begin
      usr_mode = op_q;
      usr_din  = (op_q == OP_LOAD) ? data_q : usr_dout;
    end
  end

  // Command FSM. Holds the latched command, the remaining step count, and the
  // captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_NOP;
      data_q <= '0;
      rem    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            rem    <= (cmd_op == OP_LOAD) ? CNT_W'(1) : cnt_eff;
            if (cmd_op == OP_LOAD || (is_rot && cnt_eff != '0))
              state <= S_EXEC;
            else
              state <= S_CAPT;
          end
        end
        S_EXEC: begin
          rem <= rem - CNT_W'(1);
          if (rem == CNT_W'(1))
            state <= S_CAPT;
        end
        S_CAPT: begin
          result <= usr_dout;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Directed bench for usr_shift_sequencer. It includes a behavioural 4-bit USR
// that the sequencer drives.
module tb_usr_shift_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic [1:0] usr_mode;
  logic [3:0] usr_din;
  logic [3:0] usr_dout;
  logic       busy;
  logic       done;
  logic [3:0] result;

  int tests = 0;
  int fails = 0;
  int lat;

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .usr_mode(usr_mode), .usr_din(usr_din), .usr_dout(usr_dout),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // External USR model: 01 rotate-right of din, 10 rotate-left of din, 11 load.
  logic [3:0] usr_q = 4'b0000;
  assign usr_dout = usr_q;
  always @(posedge clk) begin
    case (usr_mode)
      2'b01:   usr_q <= {usr_din[0], usr_din[3:1]};
      2'b10:   usr_q <= {usr_din[2:0], usr_din[3]};
      2'b11:   usr_q <= usr_din;
      default: usr_q <= usr_q;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a command in IDLE and take the accept edge. On return the bench is
  // in cycle 1 and cmd_valid is low.
  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [2:0] cnt);
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Issue a command and count cycles until done, with a bounded wait.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input logic [2:0] cnt, input int exp_lat, input logic [3:0] exp_res);
    issue(op, data, cnt);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1111; cmd_count = 3'd0;

    // 1. Reset with cmd_valid high
    tick();
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_mode", usr_mode, 2'b00);
    chk("rst_din", usr_din, 4'h0);
    chk("rst_result", result, 4'h0);
    chk("rst_done", done, 1'b0);
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready2", cmd_ready, 1'b0);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("rel_ready", cmd_ready, 1'b1);
    chk("rel_busy", busy, 1'b0);
    tick();
    chk("rel_usr", usr_dout, 4'h0);

    // 2. Load 1011
    issue(2'b11, 4'b1011, 3'd0);
    chk("ld_c1_busy", busy, 1'b1);
    chk("ld_c1_mode", usr_mode, 2'b11);
    chk("ld_c1_din", usr_din, 4'b1011);
    chk("ld_c1_ready", cmd_ready, 1'b0);
    tick();
    chk("ld_c2_mode", usr_mode, 2'b00);
    chk("ld_c2_busy", busy, 1'b1);
    chk("ld_c2_done", done, 1'b0);
    tick();
    chk("ld_c3_done", done, 1'b1);
    chk("ld_c3_res", result, 4'b1011);
    chk("ld_c3_ready", cmd_ready, 1'b1);
    chk("ld_c3_busy", busy, 1'b0);
    tick();
    chk("ld_c4_done", done, 1'b0);
    chk("ld_c4_res", result, 4'b1011);

    // 3. Rotate right by 1 from 1011. Inputs change after accept and must be ignored.
    issue(2'b01, 4'b0000, 3'd1);
    cmd_op = 2'b11; cmd_data = 4'b0000; cmd_count = 3'd7;
    chk("rr1_c1_mode", usr_mode, 2'b01);
    chk("rr1_c1_din", usr_din, 4'b1011);
    tick();
    chk("rr1_c2_done", done, 1'b0);
    tick();
    chk("rr1_c3_done", done, 1'b1);
    chk("rr1_c3_res", result, 4'b1101);

    // 4. Reload 1011, then rotate left by 3
    run_cmd("reload", 2'b11, 4'b1011, 3'd0, 3, 4'b1011);
    issue(2'b10, 4'b0000, 3'd3);
    chk("rl3_c1_mode", usr_mode, 2'b10);
    chk("rl3_c1_din", usr_din, 4'b1011);
    chk("rl3_c1_busy", busy, 1'b1);
    tick();
    chk("rl3_c2_din", usr_din, 4'b0111);
    chk("rl3_c2_busy", busy, 1'b1);
    tick();
    chk("rl3_c3_din", usr_din, 4'b1110);
    chk("rl3_c3_busy", busy, 1'b1);
    tick();
    chk("rl3_c4_mode", usr_mode, 2'b00);
    chk("rl3_c4_busy", busy, 1'b1);
    chk("rl3_c4_done", done, 1'b0);
    tick();
    chk("rl3_c5_done", done, 1'b1);
    chk("rl3_c5_res", result, 4'b1101);
    chk("rl3_c5_busy", busy, 1'b0);

    // 5. Back-to-back: a NOP is held valid during a rotate right by 2 of 1101
    issue(2'b01, 4'b0000, 3'd2);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'b1111; cmd_count = 3'd0;
    chk("b2b_c1_ready", cmd_ready, 1'b0);
    tick();
    chk("b2b_c2_ready", cmd_ready, 1'b0);
    tick();
    chk("b2b_c3_ready", cmd_ready, 1'b0);
    chk("b2b_c3_busy", busy, 1'b1);
    tick();
    chk("b2b_c4_done", done, 1'b1);
    chk("b2b_c4_ready", cmd_ready, 1'b1);
    chk("b2b_c4_res", result, 4'b0111);
    tick();
    cmd_valid = 1'b0;
    chk("nop_c1_busy", busy, 1'b1);
    chk("nop_c1_done", done, 1'b0);
    tick();
    chk("nop_c2_done", done, 1'b1);
    chk("nop_c2_res", result, 4'b0111);

    // A rotate with count 0 takes the NOP path
    run_cmd("rot0", 2'b10, 4'b0000, 3'd0, 2, 4'b0111);

    // 6. Rotate right by 7, with reset asserted in EXEC cycle 3
    issue(2'b01, 4'b0000, 3'd7);
    tick();
    tick();
    chk("abt_c3_busy", busy, 1'b1);
    chk("abt_c3_mode", usr_mode, 2'b01);
    rst = 1'b1;
    tick();
    chk("abt_busy", busy, 1'b0);
    chk("abt_mode", usr_mode, 2'b00);
    chk("abt_done", done, 1'b0);
    chk("abt_res", result, 4'h0);
    rst = 1'b0;
    tick();
    chk("abt_post_done", done, 1'b0);
    chk("abt_post_ready", cmd_ready, 1'b1);

    // Rotate right by 5 from 1000. Both builds give 0100; only the latency differs.
    run_cmd("ld8", 2'b11, 4'b1000, 3'd0, 3, 4'b1000);
`ifdef USR_SEQ_MOD_EN
    run_cmd("rr5", 2'b01, 4'b0000, 3'd5, 3, 4'b0100);
`else
    run_cmd("rr5", 2'b01, 4'b0000, 3'd5, 7, 4'b0100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
